// File: rtl/bht_resolve_unit_pkg.sv
// Shared types and helpers for the branch-history resolve unit.
// The checkpoint entry is the record kept for each branch between IF1 lookup and EX resolve.
package bht_resolve_unit_pkg;

  localparam int BHR_WIDTH_DEF = 4;
  localparam int HIST_MAX      = 32;

  typedef struct packed {
    logic [31:0]              pc;
    logic [BHR_WIDTH_DEF-1:0] bhr;
    logic                     pred;
  } ckpt_t;

  // Shifts at the widest supported history width. Callers narrow the result to their own width.
  function automatic logic [HIST_MAX-1:0] shift_hist(input logic [HIST_MAX-1:0] h,
                                                     input logic                b);
    return {h[HIST_MAX-2:0], b};
  endfunction

endpackage

// File: rtl/bht_resolve_unit_ckpt_fifo.sv
// Synchronous checkpoint FIFO with push, pop and clear. Clear has priority over push and pop.
// An extra wrap bit on each pointer separates the full state from the empty state.
module bht_ckpt_fifo #(
  parameter int DATA_W = 37,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !full && !clear)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bht_resolve_unit.sv
// Tracks speculative and committed global history and checkpoints each in-flight prediction.
// At EX resolve it issues the PHT update, and on a mispredict or a flush it restores the history.
module bht_resolve_unit
  import bht_resolve_unit_pkg::*;
#(
  parameter int BHR_WIDTH = BHR_WIDTH_DEF,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if1_valid,
  input  logic [31:0]          if1_pc,
  input  logic                 if1_pred,
  output logic                 if1_ready,
  output logic [BHR_WIDTH-1:0] fbhr,
  input  logic                 ex_valid,
  input  logic                 ex_taken,
  input  logic                 flush,
  output logic                 we,
  output logic                 branched,
  output logic [31:0]          ex_pc,
  output logic [BHR_WIDTH-1:0] wbhr,
  output logic                 mispredict
);

  typedef struct packed {
    logic [31:0]          pc;
    logic [BHR_WIDTH-1:0] bhr;
    logic                 pred;
  } entry_t;

  function automatic logic [BHR_WIDTH-1:0] hshift(input logic [BHR_WIDTH-1:0] h,
                                                  input logic                 b);
    return BHR_WIDTH'(shift_hist(HIST_MAX'(h), b));
  endfunction

  entry_t               head;
  entry_t               wentry;
  logic                 full;
  logic                 empty;
  logic                 resolve;
  logic                 mis;
  logic                 push;
  logic [BHR_WIDTH-1:0] cbhr;
  logic [BHR_WIDTH-1:0] cbhr_nxt;
  logic [BHR_WIDTH-1:0] fbhr_nxt;

  assign if1_ready = !full;
  assign resolve   = ex_valid && !empty;
  assign mis       = resolve && (ex_taken != head.pred);
  assign push      = if1_valid && !full && !mis && !flush;
  assign wentry    = '{pc: if1_pc, bhr: fbhr, pred: if1_pred};
  assign cbhr_nxt  = resolve ? hshift(cbhr, ex_taken) : cbhr;

  // When flush and mispredict coincide, the committed history wins because the redirect is external.
  always_comb begin
    fbhr_nxt = fbhr;
    if (flush)
      fbhr_nxt = cbhr_nxt;
    else if (mis)
      fbhr_nxt = hshift(head.bhr, ex_taken);
    else if (push)
      fbhr_nxt = hshift(fbhr, if1_pred);
  end

  bht_ckpt_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (resolve),
    .clear (mis || flush),
    .wdata (wentry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fbhr       <= '0;
      cbhr       <= '0;
      we         <= 1'b0;
      branched   <= 1'b0;
      ex_pc      <= '0;
      wbhr       <= '0;
      mispredict <= 1'b0;
    end else begin
      fbhr       <= fbhr_nxt;
      cbhr       <= cbhr_nxt;
      we         <= resolve;
      branched   <= resolve && ex_taken;
      mispredict <= mis;
      if (resolve) begin
        ex_pc <= head.pc;
        wbhr  <= head.bhr;
      end
    end
  end

endmodule
